phy_frame_gen: RTL

PHY_FRAME_GEN -- requirements
Module: phy_frame_gen

---
 rtl/phy_frame_gen.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/phy_frame_gen.sv
// Test-frame generator and fixed-delay loopback for a GMII/MII-style receive path.
// Define FRAME_GEN_CRC_EN to append a 4-byte CRC-32 FCS after each payload.
module phy_frame_gen #(
    parameter int DELAY     = 10,
    parameter int IFG_BYTES = 12,
    parameter int MAX_LEN   = 1518
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        GigaMode,
    input  logic        LinkUp,
    input  logic [1:0]  Mode,
    input  logic        Start,
    input  logic [10:0] FrameLen,
    input  logic [15:0] FrameCnt,
    input  logic        TxEn,
    input  logic [7:0]  TxData,
    output logic        RxDv,
    output logic [7:0]  RxData,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] SentCnt
);

    // state | meaning: IDLE wait for Start; IFG idle gap; PRE preamble+SFD; DATA payload; FCS crc bytes
`ifdef FRAME_GEN_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_IFG, S_PRE, S_DATA, S_FCS} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_IFG, S_PRE, S_DATA} state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  mode_q;
    logic        giga_q;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        half_q, half_d;
    logic [10:0] len_q, len_d;
    logic [15:0] frm_left_q, frm_left_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] sent_q, sent_d;
    logic        done_q, done_d;
    logic        gen_dv;
    logic [7:0]  gen_byte;
    logic [7:0]  gen_out;
    logic        byte_end;
    logic        frame_end;
    logic [10:0] len_clamp;
    logic [8:0]  lb_tap;

`ifdef FRAME_GEN_CRC_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    // The output register is the last of the DELAY stages.
    generate
        if (DELAY > 1) begin : g_dly
            logic [8:0] dly_q [DELAY-1];
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    for (int i = 0; i < DELAY - 1; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= {TxEn, TxData};
                    for (int i = 1; i < DELAY - 1; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign lb_tap = dly_q[DELAY-2];
        end else begin : g_nodly
            assign lb_tap = {TxEn, TxData};
        end
    endgenerate

    assign len_clamp = (FrameLen == 11'd0) ? 11'd1 :
                       (FrameLen > 11'(MAX_LEN)) ? 11'(MAX_LEN) : FrameLen;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        half_d     = half_q;
        len_d      = len_q;
        frm_left_d = frm_left_q;
        data_d     = data_q;
        sent_d     = sent_q;
        done_d     = 1'b0;
        gen_dv     = 1'b0;
        gen_byte   = 8'h00;
        frame_end  = 1'b0;
`ifdef FRAME_GEN_CRC_EN
        crc_d      = crc_q;
`endif
        byte_end = giga_q | half_q;
        if (state_q != S_IDLE && !giga_q) half_d = ~half_q;

        case (state_q)
            S_IDLE: begin
                half_d = 1'b0;
                if (Start && mode_q == 2'd2 && LinkUp) begin
                    sent_d = '0;
                    if (FrameCnt == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_IFG;
                        byte_cnt_d = 11'(IFG_BYTES - 1);
                        len_d      = len_clamp;
                        frm_left_d = FrameCnt;
                    end
                end
            end
            S_IFG: begin
                if (byte_end) begin
                    if (byte_cnt_q == 11'd0) begin
                        state_d    = S_PRE;
                        byte_cnt_d = 11'd7;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 11'd1;
                    end
                end
            end
            S_PRE: begin
                gen_dv   = 1'b1;
                gen_byte = (byte_cnt_q == 11'd0) ? 8'hD5 : 8'h55;
`ifdef FRAME_GEN_CRC_EN
                crc_d    = 32'hFFFFFFFF;
`endif
                if (byte_end) begin
                    if (byte_cnt_q == 11'd0) begin
                        state_d    = S_DATA;
                        byte_cnt_d = len_q - 11'd1;
                        data_d     = sent_q[7:0];
                    end else begin
                        byte_cnt_d = byte_cnt_q - 11'd1;
                    end
                end
            end
            S_DATA: begin
                gen_dv   = 1'b1;
                gen_byte = data_q;
                if (byte_end) begin
                    data_d = data_q + 8'd1;
`ifdef FRAME_GEN_CRC_EN
                    crc_d  = crc_byte(crc_q, data_q);
`endif
                    if (byte_cnt_q == 11'd0) begin
`ifdef FRAME_GEN_CRC_EN
                        state_d    = S_FCS;
                        byte_cnt_d = 11'd3;
`else
                        frame_end  = 1'b1;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q - 11'd1;
                    end
                end
            end
`ifdef FRAME_GEN_CRC_EN
            S_FCS: begin
                gen_dv   = 1'b1;
                gen_byte = ~crc_q[7:0];
                if (byte_end) begin
                    crc_d = {8'h00, crc_q[31:8]};
                    if (byte_cnt_q == 11'd0) frame_end = 1'b1;
                    else byte_cnt_d = byte_cnt_q - 11'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            sent_d = sent_q + 16'd1;
            if (frm_left_q == 16'd1) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                frm_left_d = frm_left_q - 16'd1;
                state_d    = S_IFG;
                byte_cnt_d = 11'(IFG_BYTES - 1);
            end
        end

        // Link loss wins over everything; the partial frame is not counted.
        if (state_q != S_IDLE && !LinkUp) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            gen_dv  = 1'b0;
            sent_d  = sent_q;
        end
        if (state_d == S_IDLE) half_d = 1'b0;

        gen_out = giga_q ? gen_byte : {4'h0, half_q ? gen_byte[7:4] : gen_byte[3:0]};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd3;
            giga_q     <= 1'b1;
            byte_cnt_q <= '0;
            half_q     <= 1'b0;
            len_q      <= 11'd1;
            frm_left_q <= '0;
            data_q     <= '0;
            sent_q     <= '0;
            done_q     <= 1'b0;
            RxDv       <= 1'b0;
            RxData     <= '0;
`ifdef FRAME_GEN_CRC_EN
            crc_q      <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            half_q     <= half_d;
            len_q      <= len_d;
            frm_left_q <= frm_left_d;
            data_q     <= data_d;
            sent_q     <= sent_d;
            done_q     <= done_d;
`ifdef FRAME_GEN_CRC_EN
            crc_q      <= crc_d;
`endif
            if (state_q == S_IDLE && state_d == S_IDLE) begin
                mode_q <= Mode;
                giga_q <= GigaMode;
            end
            case (mode_q)
                2'd1: {RxDv, RxData} <= lb_tap;
                2'd2: begin
                    RxDv   <= gen_dv;
                    RxData <= gen_dv ? gen_out : 8'h00;
                end
                default: begin
                    RxDv   <= 1'b0;
                    RxData <= 8'h00;
                end
            endcase
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign Done    = done_q;
    assign SentCnt = sent_q;

endmodule
